// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared memory-port widths and the I/O window address map.
package mem_responder_pkg;
  localparam int AddrWidth = 32;
  localparam int MemDataWidth = 8;
  localparam logic [AddrWidth-1:0] IO_DATA_ADDR = 32'h0003_0000;
  localparam logic [AddrWidth-1:0] IO_STAT_ADDR = 32'h0003_0004;
  localparam int IoSelHi = 17;
  localparam int IoSelLo = 16;
  localparam logic [IoSelHi-IoSelLo:0] IoSel = 2'b11;
  function automatic logic is_io(input logic [AddrWidth-1:0] a);
    return a[IoSelHi:IoSelLo] == IoSel;
  endfunction
endpackage

// File: rtl/mem_responder_byte_fifo.sv
// byte_fifo: power-of-two circular FIFO with occupancy count, async active-low reset.
module byte_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk_in)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  assign dout = mem[rd_ptr];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: byte-wide memory port endpoint backing a RAM plus a UART TX/RX I/O window.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int TX_FIFO_DEPTH = 8
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic [AddrWidth-1:0]    mem_a_in,
  input  logic [MemDataWidth-1:0] mem_d_in,
  input  logic                    mem_wr_in,
  output logic [MemDataWidth-1:0] mem_d_out,
  output logic                    io_buffer_full_out,
  output logic [MemDataWidth-1:0] io_tx_data_out,
  output logic                    io_tx_valid_out,
  input  logic                    io_tx_ready_in,
  input  logic [MemDataWidth-1:0] io_rx_data_in,
  input  logic                    io_rx_valid_in,
  output logic                    io_rx_ready_out,
  output logic                    tx_overflow_out,
  output logic                    sim_end_out
);
  localparam int CW = $clog2(TX_FIFO_DEPTH) + 1;
  logic [MemDataWidth-1:0] ram [2**RAM_ADDR_WIDTH];
  logic [RAM_ADDR_WIDTH-1:0] ram_idx;
  logic [MemDataWidth-1:0] rx_data, tx_head, rd_data;
  logic [CW-1:0] tx_count;
  logic rx_full, tx_full, tx_empty;
  logic io_sel, data_sel, stat_sel, tx_req, tx_push, tx_pop, rx_take, data_rd;
  always_comb begin
    ram_idx = mem_a_in[RAM_ADDR_WIDTH-1:0];
    io_sel = is_io(mem_a_in);
    data_sel = mem_a_in == IO_DATA_ADDR;
    stat_sel = mem_a_in == IO_STAT_ADDR;
    tx_pop = rdy_in && !tx_empty && io_tx_ready_in;
    tx_req = rdy_in && mem_wr_in && data_sel;
    tx_push = tx_req && (!tx_full || tx_pop);
    data_rd = !mem_wr_in && data_sel;
    rx_take = io_rx_valid_in && !rx_full;
    rd_data = data_sel ? (rx_full ? rx_data : '0) :
              stat_sel ? {6'b0, rx_full, tx_full} :
              io_sel ? '0 : ram[ram_idx];
  end
  always_ff @(posedge clk_in)
    if (rdy_in && mem_wr_in && !io_sel) ram[ram_idx] <= mem_d_in;
  // sim_end_out is a pure pulse: it never lingers while rdy_in is low
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      mem_d_out <= '0;
      rx_full <= 1'b0;
      rx_data <= '0;
      tx_overflow_out <= 1'b0;
      sim_end_out <= 1'b0;
    end else begin
      sim_end_out <= rdy_in && mem_wr_in && stat_sel;
      tx_overflow_out <= tx_overflow_out || (tx_req && !tx_push);
      if (rdy_in) begin
        if (!mem_wr_in) mem_d_out <= rd_data;
        if (rx_take) begin
          rx_full <= 1'b1;
          rx_data <= io_rx_data_in;
        end else if (data_rd) rx_full <= 1'b0;
      end
    end
  byte_fifo #(.DEPTH(TX_FIFO_DEPTH), .WIDTH(MemDataWidth)) u_tx_fifo (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .push(tx_push),
    .pop(tx_pop),
    .din(mem_d_in),
    .dout(tx_head),
    .full(tx_full),
    .empty(tx_empty),
    .count(tx_count)
  );
  assign io_tx_data_out = tx_head;
  assign io_tx_valid_out = !tx_empty;
  assign io_buffer_full_out = tx_count >= CW'(TX_FIFO_DEPTH - 1);
  assign io_rx_ready_out = !rx_full;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: table vectors, directed corner sequences and random traffic vs a queue-based model.
module tb_mem_responder;
  localparam int DEPTH = 8;
  logic clk_in = 0, rst_in = 0, rdy_in = 0, mem_wr_in = 0, io_tx_ready_in = 0, io_rx_valid_in = 0;
  logic [31:0] mem_a_in = 0;
  logic [7:0] mem_d_in = 0, io_rx_data_in = 0;
  logic [7:0] mem_d_out, io_tx_data_out;
  logic io_buffer_full_out, io_tx_valid_out, io_rx_ready_out, tx_overflow_out, sim_end_out;
  int checks = 0, errors = 0;
  logic [7:0] m_ram [int];
  logic [7:0] m_q [$];
  logic [7:0] m_d = 0, m_rxb = 0;
  logic m_dk = 1, m_rxf = 0, m_ovf = 0, m_end = 0;
  typedef struct {
    logic [31:0] a;
    logic [7:0] d;
    logic wr;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl [12];
  always #5 clk_in = ~clk_in;
  mem_responder dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .mem_a_in(mem_a_in), .mem_d_in(mem_d_in), .mem_wr_in(mem_wr_in), .mem_d_out(mem_d_out),
    .io_buffer_full_out(io_buffer_full_out), .io_tx_data_out(io_tx_data_out),
    .io_tx_valid_out(io_tx_valid_out), .io_tx_ready_in(io_tx_ready_in),
    .io_rx_data_in(io_rx_data_in), .io_rx_valid_in(io_rx_valid_in), .io_rx_ready_out(io_rx_ready_out),
    .tx_overflow_out(tx_overflow_out), .sim_end_out(sim_end_out)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset;
    m_q.delete();
    m_d = 0;
    m_dk = 1;
    m_rxf = 0;
    m_rxb = 0;
    m_ovf = 0;
    m_end = 0;
  endtask
  task automatic check_model;
    if (m_dk) chk("mem_d_out", mem_d_out, m_d);
    chk("tx_valid", io_tx_valid_out, m_q.size() != 0);
    if (m_q.size() != 0) chk("tx_data", io_tx_data_out, m_q[0]);
    chk("buf_full", io_buffer_full_out, m_q.size() >= DEPTH - 1);
    chk("overflow", tx_overflow_out, m_ovf);
    chk("rx_ready", io_rx_ready_out, !m_rxf);
    chk("sim_end", sim_end_out, m_end);
  endtask
  task automatic step(input logic [31:0] a, input logic [7:0] d, input logic wr, input logic txr,
                      input logic rxv, input logic [7:0] rxd, input logic rdy);
    logic io, dsel, ssel, old;
    int idx;
    mem_a_in = a; mem_d_in = d; mem_wr_in = wr; io_tx_ready_in = txr;
    io_rx_valid_in = rxv; io_rx_data_in = rxd; rdy_in = rdy;
    io = a[17:16] == 2'b11;
    dsel = a == 32'h30000;
    ssel = a == 32'h30004;
    idx = int'(a & 32'h1FFFF);
    m_end = 0;
    if (rdy) begin
      if (!wr) begin
        if (dsel) begin m_d = m_rxf ? m_rxb : 8'h00; m_dk = 1; end
        else if (ssel) begin m_d = {6'b0, m_rxf, m_q.size() == DEPTH}; m_dk = 1; end
        else if (io) begin m_d = 0; m_dk = 1; end
        else begin m_dk = m_ram.exists(idx); m_d = m_dk ? m_ram[idx] : 8'h00; end
      end else if (!io) m_ram[idx] = d;
      if (m_q.size() != 0 && txr) void'(m_q.pop_front());
      if (wr && dsel) begin
        if (m_q.size() < DEPTH) m_q.push_back(d);
        else m_ovf = 1;
      end
      old = m_rxf;
      if (!wr && dsel) m_rxf = 0;
      if (rxv && !old) begin m_rxf = 1; m_rxb = rxd; end
      m_end = wr && ssel;
    end
    @(posedge clk_in);
    #1;
    check_model();
  endtask
  task automatic do_reset;
    rst_in = 0;
    @(posedge clk_in);
    #1;
    rst_in = 1;
    model_reset();
  endtask
  initial begin
    logic [31:0] a;
    int k;
    tbl[0]  = '{32'h10,  8'hA5, 1'b1, 8'h00};
    tbl[1]  = '{32'h10,  8'h00, 1'b0, 8'hA5};
    tbl[2]  = '{32'h100, 8'h11, 1'b1, 8'hA5};
    tbl[3]  = '{32'h101, 8'h22, 1'b1, 8'hA5};
    tbl[4]  = '{32'h102, 8'h33, 1'b1, 8'hA5};
    tbl[5]  = '{32'h103, 8'h44, 1'b1, 8'hA5};
    tbl[6]  = '{32'h100, 8'h00, 1'b0, 8'h11};
    tbl[7]  = '{32'h101, 8'h00, 1'b0, 8'h22};
    tbl[8]  = '{32'h102, 8'h00, 1'b0, 8'h33};
    tbl[9]  = '{32'h103, 8'h00, 1'b0, 8'h44};
    tbl[10] = '{32'h0,   8'h77, 1'b1, 8'h44};
    tbl[11] = '{32'h0,   8'h00, 1'b0, 8'h77};
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1;
    rdy_in = 1;
    chk("rst_d_out", mem_d_out, 0);
    chk("rst_tx_valid", io_tx_valid_out, 0);
    chk("rst_rx_ready", io_rx_ready_out, 1);
    chk("rst_overflow", tx_overflow_out, 0);
    chk("rst_sim_end", sim_end_out, 0);
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].a, tbl[i].d, tbl[i].wr, 0, 0, 0, 1);
      chk($sformatf("vec%0d", i), mem_d_out, tbl[i].exp);
    end
    for (int i = 1; i <= 9; i++) begin
      step(32'h30000, 8'(i), 1, 0, 0, 0, 1);
      chk($sformatf("fill_full%0d", i), io_buffer_full_out, i >= 7);
    end
    chk("ovf_after_9", tx_overflow_out, 1);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("drain%0d", i), io_tx_data_out, i);
      step(32'h0, 0, 0, 1, 0, 0, 1);
    end
    chk("drained_valid", io_tx_valid_out, 0);
    do_reset();
    for (int i = 0; i < 8; i++) step(32'h30000, 8'(8'h10 + i), 1, 0, 0, 0, 1);
    step(32'h30000, 8'h99, 1, 1, 0, 0, 1);
    chk("pp_overflow", tx_overflow_out, 0);
    chk("pp_head", io_tx_data_out, 8'h11);
    step(32'h30004, 0, 0, 0, 0, 0, 1);
    chk("pp_status_full", mem_d_out, 8'h01);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("pp_order%0d", i), io_tx_data_out, i == 8 ? 8'h99 : 8'(8'h10 + i));
      step(32'h0, 0, 0, 1, 0, 0, 1);
    end
    chk("pp_empty", io_tx_valid_out, 0);
    step(32'h0, 0, 0, 0, 1, 8'h5A, 1);
    chk("rx_ready_low", io_rx_ready_out, 0);
    step(32'h30004, 0, 0, 0, 0, 0, 1);
    chk("rx_status", mem_d_out, 8'h02);
    step(32'h30000, 0, 0, 0, 0, 0, 1);
    chk("rx_data", mem_d_out, 8'h5A);
    step(32'h30000, 0, 0, 0, 0, 0, 1);
    chk("rx_empty_read", mem_d_out, 8'h00);
    chk("rx_ready_back", io_rx_ready_out, 1);
    step(32'h10, 8'hEE, 1, 0, 0, 0, 0);
    step(32'h30004, 8'h01, 1, 0, 0, 0, 0);
    chk("end_frozen", sim_end_out, 0);
    step(32'h10, 0, 0, 0, 0, 0, 1);
    chk("ram_frozen", mem_d_out, 8'hA5);
    step(32'h30004, 8'h01, 1, 0, 0, 0, 1);
    chk("end_pulse", sim_end_out, 1);
    step(32'h0, 0, 0, 0, 0, 0, 1);
    chk("end_pulse_off", sim_end_out, 0);
    for (int i = 0; i < 4; i++) step(32'h30000, 8'(8'hC0 + i), 1, 0, 0, 0, 1);
    step(32'h10, 0, 0, 1, 0, 0, 1);
    #3;
    rst_in = 0;
    #1;
    chk("async_tx_valid", io_tx_valid_out, 0);
    chk("async_d_out", mem_d_out, 0);
    model_reset();
    @(posedge clk_in);
    #1;
    rst_in = 1;
    check_model();
    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 9);
      a = k < 6 ? (($urandom & 32'hFFFC0000) | 32'($urandom_range(0, 15))) :
          k < 8 ? 32'h30000 : k == 8 ? 32'h30004 : 32'h30008;
      step(a, 8'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 2) == 0,
           8'($urandom), $urandom_range(0, 9) != 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side endpoint of the byte-wide memory port that the allocator drives: one byte per cycle, address plus write strobe in, read data out.
- Backs a byte-addressed RAM and decodes a small memory-mapped I/O window: a UART TX FIFO, an RX holding register, status, and a simulation-end register.
- Sits between the CPU core's memory port and the board RAM/UART wrappers. It serves both the simulation top and the FPGA top.

Parameters:
RAM_ADDR_WIDTH, 17, RAM byte address bits; RAM holds 2^RAM_ADDR_WIDTH bytes; mem_a_in aliases modulo this size.
TX_FIFO_DEPTH, 8, TX FIFO entries (power of two, >=4).

Ports:
clk_in  input  1  clock, all state on rising edge
rst_in  input  1  asynchronous, active-low reset
rdy_in  input  1  global enable; low freezes all state
mem_a_in  input  32  byte address from allocator
mem_d_in  input  8  write data byte
mem_wr_in  input  1  1 = write, 0 = read
mem_d_out  output  8  read data, valid one cycle after the address
io_buffer_full_out  output  1  TX FIFO nearly full (count >= TX_FIFO_DEPTH-1)
io_tx_data_out  output  8  byte toward UART
io_tx_valid_out  output  1  TX FIFO non-empty
io_tx_ready_in  input  1  UART accepts byte this cycle
io_rx_data_in  input  8  byte from UART
io_rx_valid_in  input  1  UART byte valid
io_rx_ready_out  output  1  RX holding register empty
tx_overflow_out  output  1  sticky: an I/O write was dropped
sim_end_out  output  1  one-cycle pulse on write to END register

Behaviour:
- Address decode (mem_a_in[17:16] == 2'b11 selects I/O, otherwise RAM):
  - 0x30000 DATA: write pushes TX FIFO; read pops RX.
  - 0x30004 STATUS/END: read returns {6'b0, rx_full, tx_full}; write pulses sim_end_out.
  - Other I/O addresses: reads return 0, writes are ignored.
- Reset (rst_in low, asynchronous):
  - mem_d_out=0; FIFO pointers and count=0; rx_full=0.
  - tx_overflow_out=0, sim_end_out=0.
  - RAM contents are not reset.
- All updates below happen only when rdy_in=1. With rdy_in=0, every register including mem_d_out holds.
- RAM write: when mem_wr_in=1 and the address is in RAM, ram[a] <= mem_d_in at that edge. mem_d_out is unchanged that cycle.
- RAM read: address presented in cycle N; ram[a] appears on mem_d_out after the edge ending cycle N, so it is valid throughout cycle N+1.
  - Back-to-back reads stream one byte per cycle.
  - Read-after-write to the same address in the next cycle returns the new byte.
- Idle allocator cycles (a=0, wr=0) are ordinary side-effect-free RAM reads.
- DATA write:
  - Accepted if the FIFO is not full, or if the FIFO is full and a TX pop occurs in the same cycle.
  - Otherwise the byte is dropped and tx_overflow_out is set (cleared only by reset).
- DATA read:
  - If rx_full, mem_d_out <= rx byte next cycle and rx_full clears.
  - If empty, mem_d_out <= 0.
- TX drain:
  - io_tx_data_out is the FIFO head; io_tx_valid_out = (count != 0).
  - A pop happens when valid and io_tx_ready_in are both high.
  - Simultaneous push and pop leave count unchanged; pointers wrap modulo depth.
- RX capture:
  - io_rx_ready_out = !rx_full.
  - On io_rx_valid_in and ready, latch the byte and set rx_full.
  - A DATA read and an arrival in the same cycle: the read returns the old byte (if any), and the new byte is latched (ready was high only if the register was empty, so there is no loss).
- STATUS read reflects the registered flags before that cycle's updates.
- sim_end_out is high for exactly one cycle per END write. A write with rdy_in=0 produces no pulse.
- Reset mid-stream discards FIFO/RX data immediately. mem_d_out goes to 0 asynchronously.

Decomposition:
- Shared package/header (existing config include): AddrWidth=32, MemDataWidth=8, IO_DATA_ADDR=32'h30000, IO_STAT_ADDR=32'h30004, IO region select bits.
- One sub-module: byte_fifo (parameterised depth, push/pop/full/empty/count, async active-low reset), instantiated for TX.

Test Plan:
- Reset, then write 0xA5 to 0x00010 and read 0x00010 next cycle -> mem_d_out=0xA5 exactly one cycle after the read address.
- Stream reads of 0x100..0x103 holding bytes 11,22,33,44 -> mem_d_out shows 11,22,33,44 on consecutive cycles, lagging the address by one.
- io_tx_ready_in=0; write DATA 9 times with depth 8:
  - io_buffer_full_out rises after the 7th write.
  - The 9th write is dropped and tx_overflow_out=1.
  - Then raise ready: bytes drain in order, valid falls after 8 pops.
- Full FIFO with push and pop in the same cycle -> count stays 8, no overflow, order preserved.
- RX: drive 0x5A with valid:
  - io_rx_ready_out falls.
  - STATUS read returns 0x02; DATA read returns 0x5A; a second DATA read returns 0x00.
- rdy_in=0 during a RAM write and an END write -> RAM unchanged, no sim_end_out pulse. Async reset asserted mid-drain -> io_tx_valid_out=0 and mem_d_out=0 before the next clock edge.
